// File: rtl/spatial_gate_fusion_unit_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for the spatial gate fusion unit.
// The *_D values are the block's default geometry.
package spatial_gate_fusion_unit_pkg;
    localparam int DATA_W_D    = 8;
    localparam int IN_CH_D     = 8;
    localparam int K_DIM_D     = 3;
    localparam int IMG_W_D     = 5;
    localparam int IMG_H_D     = 4;
    localparam int GATE_FRAC_D = 7;
    localparam int FM_ADDR_W_D = 10;
    localparam int GATE_RND_D  = 1 << (GATE_FRAC_D - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

    function automatic int rnd_const(input int frac);
        return (frac > 0) ? (1 << (frac - 1)) : 0;
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction
endpackage

// File: rtl/spatial_gate_fusion_unit_if.sv
// Memory-side bus of the fusion unit: gate/feature read ports and output buffer write port.
// Signal prefixes are from the unit's (master) point of view.
interface spatial_gate_fusion_unit_if
    import spatial_gate_fusion_unit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_D,
    parameter int FM_ADDR_W = FM_ADDR_W_D
);
    logic [FM_ADDR_W-1:0] o_gate_rd_addr;
    logic [DATA_W-1:0]    i_gate_rd_data;
    logic                 o_fm_rd_en;
    logic [FM_ADDR_W-1:0] o_fm_rd_addr;
    logic [DATA_W-1:0]    i_fm_rd_data;
    logic                 o_out_wr_en;
    logic [FM_ADDR_W-1:0] o_out_wr_addr;
    logic [DATA_W-1:0]    o_out_wr_data;

    modport master (
        output o_gate_rd_addr, o_fm_rd_en, o_fm_rd_addr,
        output o_out_wr_en, o_out_wr_addr, o_out_wr_data,
        input  i_gate_rd_data, i_fm_rd_data
    );

    modport slave (
        input  o_gate_rd_addr, o_fm_rd_en, o_fm_rd_addr,
        input  o_out_wr_en, o_out_wr_addr, o_out_wr_data,
        output i_gate_rd_data, i_fm_rd_data
    );
endinterface

// File: rtl/spatial_gate_fusion_unit_gate_mult_round_sat.sv
// Two-stage gated multiply: registered signed product, then round-half-up, shift and
// saturate into the output register. Valid travels alongside; everything holds when clk_en=0.
module gate_mult_round_sat
    import spatial_gate_fusion_unit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_D,
    parameter int GATE_FRAC = GATE_FRAC_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clk_en,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_fm,
    input  logic [DATA_W-1:0] i_gate,
    output logic              o_s1_vld,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);
    localparam int PW = 2 * DATA_W + 1;
    localparam logic signed [PW-1:0] RND  = PW'(rnd_const(GATE_FRAC));
    localparam logic signed [PW-1:0] SMAX = PW'(sat_max(DATA_W));
    localparam logic signed [PW-1:0] SMIN = PW'(sat_min(DATA_W));

    logic [1:0]                   r_vld_pipe;
    logic signed [2*DATA_W-1:0]   r_prod;
    logic [DATA_W-1:0]            r_data;
    logic signed [2*DATA_W-1:0]   w_fm_x, w_gate_x;
    logic signed [PW-1:0]         w_rnd;

    assign w_fm_x   = $signed({{DATA_W{i_fm[DATA_W-1]}}, i_fm});
    assign w_gate_x = $signed({{DATA_W{i_gate[DATA_W-1]}}, i_gate});
    // One guard bit above the product keeps the rounding add from wrapping.
    assign w_rnd    = ($signed({r_prod[2*DATA_W-1], r_prod}) + RND) >>> GATE_FRAC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_prod     <= '0;
            r_data     <= '0;
        end else if (i_clk_en) begin
            r_vld_pipe <= {r_vld_pipe[0], i_vld};
            r_prod     <= w_fm_x * w_gate_x;
            if (w_rnd > SMAX)      r_data <= SMAX[DATA_W-1:0];
            else if (w_rnd < SMIN) r_data <= SMIN[DATA_W-1:0];
            else                   r_data <= w_rnd[DATA_W-1:0];
        end
    end

    assign o_s1_vld = r_vld_pipe[0];
    assign o_vld    = r_vld_pipe[1];
    assign o_data   = r_data;
endmodule

// File: rtl/spatial_gate_fusion_unit.sv
// Walks the valid conv region of the feature map, reads each channel with its pixel's gate
// and streams gated samples to the output buffer in strictly sequential address order.
module spatial_gate_fusion_unit
    import spatial_gate_fusion_unit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_D,
    parameter int IN_CH     = IN_CH_D,
    parameter int K_DIM     = K_DIM_D,
    parameter int IMG_W     = IMG_W_D,
    parameter int IMG_H     = IMG_H_D,
    parameter int GATE_FRAC = GATE_FRAC_D,
    parameter int FM_ADDR_W = FM_ADDR_W_D
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clk_en,
    input  logic i_start,
    output logic o_done,
    output logic o_busy,
    spatial_gate_fusion_unit_if.master bus
);
    localparam int OFF  = K_DIM / 2;
    localparam int GH   = IMG_H - K_DIM + 1;
    localparam int GW   = IMG_W - K_DIM + 1;
    localparam int NPIX = GH * GW;
    localparam int N    = NPIX * IN_CH;
    localparam int CW   = FM_ADDR_W + 1;

    state_e               r_state, w_state_nxt;
    logic [FM_ADDR_W-1:0] r_p, r_row, r_col, r_ch;
    logic [FM_ADDR_W-1:0] r_fm_addr, r_gate_addr, r_out_addr;
    logic [CW-1:0]        r_wr_idx;
    logic [1:0]           r_vld_pipe;
    logic                 w_issue, w_ch_last, w_col_last, w_p_last;
    logic                 w_s1_vld, w_out_vld;
    logic [DATA_W-1:0]    w_out_data;
    logic [FM_ADDR_W-1:0] w_fm_addr;

    // Row/column counters avoid a divider for p/GW and p%GW.
    assign w_fm_addr  = FM_ADDR_W'(((int'(r_row) + OFF) * IMG_W + int'(r_col) + OFF) * IN_CH
                                   + int'(r_ch));
    assign w_ch_last  = (r_ch  == FM_ADDR_W'(IN_CH - 1));
    assign w_col_last = (r_col == FM_ADDR_W'(GW - 1));
    assign w_p_last   = (r_p   == FM_ADDR_W'(NPIX - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN: begin
                w_issue = 1'b1;
                if (w_ch_last && w_p_last) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: if (r_wr_idx == CW'(N)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_ch        <= '0;
            r_fm_addr   <= '0;
            r_gate_addr <= '0;
            r_out_addr  <= '0;
            r_wr_idx    <= '0;
            r_vld_pipe  <= '0;
        end else if (i_clk_en) begin
            r_state    <= w_state_nxt;
            // Stage 0 is the registered read request; stage 1 marks memory data returning.
            r_vld_pipe <= {r_vld_pipe[0], w_issue};
            if (r_state == S_IDLE && i_start) begin
                r_p      <= '0;
                r_row    <= '0;
                r_col    <= '0;
                r_ch     <= '0;
                r_wr_idx <= '0;
            end else begin
                if (w_issue) begin
                    r_fm_addr   <= w_fm_addr;
                    r_gate_addr <= r_p;
                    if (w_ch_last) begin
                        r_ch <= '0;
                        r_p  <= r_p + 1'b1;
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                if (w_s1_vld) begin
                    r_out_addr <= r_wr_idx[FM_ADDR_W-1:0];
                    r_wr_idx   <= r_wr_idx + 1'b1;
                end
            end
        end
    end

    gate_mult_round_sat #(.DATA_W(DATA_W), .GATE_FRAC(GATE_FRAC)) u_mult (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clk_en (i_clk_en),
        .i_vld    (r_vld_pipe[1]),
        .i_fm     (bus.i_fm_rd_data),
        .i_gate   (bus.i_gate_rd_data),
        .o_s1_vld (w_s1_vld),
        .o_vld    (w_out_vld),
        .o_data   (w_out_data)
    );

    assign bus.o_fm_rd_en     = r_vld_pipe[0];
    assign bus.o_fm_rd_addr   = r_fm_addr;
    assign bus.o_gate_rd_addr = r_gate_addr;
    assign bus.o_out_wr_en    = w_out_vld;
    assign bus.o_out_wr_addr  = r_out_addr;
    assign bus.o_out_wr_data  = w_out_data;
    assign o_done             = (r_state == S_DONE);
    assign o_busy             = (r_state == S_RUN) || (r_state == S_FLUSH);
endmodule
